port_bus_arbiter: RTL and testbench

Two-master arbiter and sequencer for the processor-style I/O port bus (PORT_ID, OUT_PORT, IN_PORT, READ_STROBE, WRITE_STROBE) that feeds the one-hot port address decoder. Master 0 and master 1 each issue single read or write transactions; the block grants round-robin. Each granted transaction is sequenced as setup, single-cycle strobe, optional read wait, then completion. PORT_ID is stable one full cycle before any strobe, so the combinational decoder never sees a strobe with a changing address.

---
 rtl/port_bus_arbiter_pkg.sv | 27 ++
 rtl/port_bus_arbiter_rr_arb2.sv | 22 ++
 rtl/port_bus_arbiter.sv | 148 ++++++++++++++
 tb/tb_port_bus_arbiter.sv | 236 +++++++++++++++++++++++
 4 files changed

// File: rtl/port_bus_arbiter_pkg.sv
// Shared definitions for the two-master port bus arbiter: sequencer state
// encoding, default bus widths and PORT_ID field positions.
package port_bus_arbiter_pkg;

    // Default data and port address widths.
    localparam int DEF_DW = 16;
    localparam int DEF_AW = 16;

    // PORT_ID field positions seen by the one-hot decoder.
    localparam int CHAN_MSB = 15;
    localparam int CHAN_LSB = 14;
    localparam int REG_MSB  = 3;
    localparam int REG_LSB  = 0;

    // Read wait counter width; bounds the legal read latency to 1..15.
    localparam int CNT_W = 4;

    // Transaction sequencer states.
    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_SETUP  = 3'd1,
        ST_STROBE = 3'd2,
        ST_WAIT   = 3'd3,
        ST_DONE   = 3'd4
    } state_t;

endpackage

// File: rtl/port_bus_arbiter_rr_arb2.sv
// Two-requester round-robin picker. When both masters request, the one
// that did not win last time is chosen; a lone requester always wins.
module rr_arb2 (
    input  logic REQ0,
    input  logic REQ1,
    input  logic LAST,
    output logic VALID,
    output logic WINNER
);

    // Pick a winner from the current requests and the previous owner.
    always_comb begin
        VALID  = REQ0 | REQ1;
        WINNER = 1'b0;
        if (REQ0 && REQ1) begin
            WINNER = ~LAST;
        end else if (REQ1) begin
            WINNER = 1'b1;
        end
    end

endmodule

// File: rtl/port_bus_arbiter.sv
// Two-master arbiter and sequencer for the processor-style I/O port bus.
// Each granted transaction runs SETUP -> STROBE -> (WAIT) -> DONE, so
// PORT_ID is stable a full cycle before any strobe reaches the decoder.
module port_bus_arbiter
    import port_bus_arbiter_pkg::*;
#(
    parameter int DW     = DEF_DW,
    parameter int AW     = DEF_AW,
    parameter int RD_LAT = 1
) (
    input  logic          CLK,
    input  logic          RESET,
    input  logic          REQ0,
    input  logic          REQ1,
    input  logic          WE0,
    input  logic          WE1,
    input  logic [AW-1:0] ADDR0,
    input  logic [AW-1:0] ADDR1,
    input  logic [DW-1:0] WDATA0,
    input  logic [DW-1:0] WDATA1,
    output logic          ACK0,
    output logic          ACK1,
    output logic [DW-1:0] RDATA,
    output logic [AW-1:0] PORT_ID,
    output logic [DW-1:0] OUT_PORT,
    input  logic [DW-1:0] IN_PORT,
    output logic          READ_STROBE,
    output logic          WRITE_STROBE,
    output logic          BUSY,
    output logic          GRANT
);

    localparam logic [CNT_W-1:0] RD_LAT_CNT = CNT_W'(RD_LAT);
    localparam logic [CNT_W-1:0] CNT_ONE    = CNT_W'(1);

    state_t             state_q;
    state_t             state_d;
    logic               last_q;
    logic               we_q;
    logic [CNT_W-1:0]   cnt_q;

    logic               arb_valid;
    logic               arb_winner;
    logic               sel_we;
    logic [AW-1:0]      sel_addr;
    logic [DW-1:0]      sel_wdata;

    rr_arb2 u_rr_arb2 (
        .REQ0   (REQ0),
        .REQ1   (REQ1),
        .LAST   (last_q),
        .VALID  (arb_valid),
        .WINNER (arb_winner)
    );

    // Winner's request fields, captured only on the grant edge.
    assign sel_we    = arb_winner ? WE1    : WE0;
    assign sel_addr  = arb_winner ? ADDR1  : ADDR0;
    assign sel_wdata = arb_winner ? WDATA1 : WDATA0;

    // Sequencer state register.
    // NOTE: every flop in this design is updated with <= so all registers
    // sample the same pre-edge values; blocking = here would create order
    // dependent simulation races between always_ff blocks.
    always_ff @(posedge CLK or negedge RESET) begin
        if (!RESET) begin
            state_q <= ST_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state logic for the transaction sequencer.
    // NOTE: state_d gets its default before the case so every path assigns
    // it and no latch is inferred.
    always_comb begin
        state_d = state_q;
        unique case (state_q)
            ST_IDLE:   if (arb_valid) state_d = ST_SETUP;
            ST_SETUP:  state_d = ST_STROBE;
            ST_STROBE: state_d = we_q ? ST_DONE : ST_WAIT;
            ST_WAIT:   if (cnt_q <= CNT_ONE) state_d = ST_DONE;
            ST_DONE:   state_d = ST_IDLE;
            default:   state_d = ST_IDLE;
        endcase
    end

    // Grant capture: owner, round-robin pointer, address and write data.
    always_ff @(posedge CLK or negedge RESET) begin
        if (!RESET) begin
            GRANT    <= 1'b0;
            last_q   <= 1'b1;
            we_q     <= 1'b0;
            PORT_ID  <= '0;
            OUT_PORT <= '0;
        end else if (state_q == ST_IDLE && arb_valid) begin
            GRANT   <= arb_winner;
            last_q  <= arb_winner;
            we_q    <= sel_we;
            PORT_ID <= sel_addr;
            if (sel_we) begin
                OUT_PORT <= sel_wdata;
            end
        end
    end

    // Read wait counter: loaded on the strobe, counts down through WAIT.
    always_ff @(posedge CLK or negedge RESET) begin
        if (!RESET) begin
            cnt_q <= '0;
        end else if (state_q == ST_STROBE) begin
            cnt_q <= RD_LAT_CNT;
        end else if (state_q == ST_WAIT) begin
            cnt_q <= cnt_q - CNT_ONE;
        end
    end

    // Read data capture at the end of the last WAIT cycle; held otherwise.
    always_ff @(posedge CLK or negedge RESET) begin
        if (!RESET) begin
            RDATA <= '0;
        end else if (state_q == ST_WAIT && cnt_q <= CNT_ONE) begin
            RDATA <= IN_PORT;
        end
    end

    // Registered strobes, acknowledges and busy, decoded from the next state.
    always_ff @(posedge CLK or negedge RESET) begin
        if (!RESET) begin
            BUSY         <= 1'b0;
            WRITE_STROBE <= 1'b0;
            READ_STROBE  <= 1'b0;
            ACK0         <= 1'b0;
            ACK1         <= 1'b0;
        end else begin
            BUSY         <= (state_d != ST_IDLE);
            WRITE_STROBE <= (state_d == ST_STROBE) &&  we_q;
            READ_STROBE  <= (state_d == ST_STROBE) && !we_q;
            ACK0         <= (state_d == ST_DONE) && !GRANT;
            ACK1         <= (state_d == ST_DONE) &&  GRANT;
        end
    end

    // Simulation-only guard on the read latency range.
    a_rd_lat_legal: assert property (@(posedge CLK) disable iff (!RESET)
        (RD_LAT >= 1 && RD_LAT <= 15));

endmodule

// File: tb/tb_port_bus_arbiter.sv
// Directed bench for port_bus_arbiter: one instance with RD_LAT=1 and one
// with RD_LAT=3 share the stimulus; expected values are hand-computed
// with the grant edge as cycle 0.
module tb_port_bus_arbiter;

    logic        CLK = 1'b0;
    logic        RESET;
    logic        REQ0, REQ1, WE0, WE1;
    logic [15:0] ADDR0, ADDR1, WDATA0, WDATA1, IN_PORT;

    logic        ACK0, ACK1, READ_STROBE, WRITE_STROBE, BUSY, GRANT;
    logic [15:0] RDATA, PORT_ID, OUT_PORT;

    logic        d3_ack0, d3_ack1, d3_rs, d3_ws, d3_busy, d3_grant;
    logic [15:0] d3_rdata, d3_port_id, d3_out_port;

    int n_checks = 0;
    int n_errors = 0;

    always #5 CLK = ~CLK;

    port_bus_arbiter #(.DW(16), .AW(16), .RD_LAT(1)) u_dut (
        .CLK(CLK), .RESET(RESET),
        .REQ0(REQ0), .REQ1(REQ1), .WE0(WE0), .WE1(WE1),
        .ADDR0(ADDR0), .ADDR1(ADDR1), .WDATA0(WDATA0), .WDATA1(WDATA1),
        .ACK0(ACK0), .ACK1(ACK1), .RDATA(RDATA), .PORT_ID(PORT_ID),
        .OUT_PORT(OUT_PORT), .IN_PORT(IN_PORT),
        .READ_STROBE(READ_STROBE), .WRITE_STROBE(WRITE_STROBE),
        .BUSY(BUSY), .GRANT(GRANT)
    );

    port_bus_arbiter #(.DW(16), .AW(16), .RD_LAT(3)) u_dut3 (
        .CLK(CLK), .RESET(RESET),
        .REQ0(REQ0), .REQ1(REQ1), .WE0(WE0), .WE1(WE1),
        .ADDR0(ADDR0), .ADDR1(ADDR1), .WDATA0(WDATA0), .WDATA1(WDATA1),
        .ACK0(d3_ack0), .ACK1(d3_ack1), .RDATA(d3_rdata), .PORT_ID(d3_port_id),
        .OUT_PORT(d3_out_port), .IN_PORT(IN_PORT),
        .READ_STROBE(d3_rs), .WRITE_STROBE(d3_ws),
        .BUSY(d3_busy), .GRANT(d3_grant)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    // Advance to 1 time unit after the next rising edge.
    task automatic cyc();
        @(posedge CLK);
        #1;
    endtask

    task automatic clear_inputs();
        REQ0 = 0; REQ1 = 0; WE0 = 0; WE1 = 0;
        ADDR0 = '0; ADDR1 = '0; WDATA0 = '0; WDATA1 = '0; IN_PORT = '0;
    endtask

    // Reset both instances, release on a falling edge.
    task automatic do_reset();
        RESET = 1'b0;
        clear_inputs();
        repeat (2) @(posedge CLK);
        @(negedge CLK);
        RESET = 1'b1;
    endtask

    initial begin
        clear_inputs();
        RESET = 1'b1;
        #2 RESET = 1'b0;
        #1;
        // Reset state
        check("rst busy", BUSY, 0);
        check("rst grant", GRANT, 0);
        check("rst port_id", PORT_ID, 0);
        check("rst out_port", OUT_PORT, 0);
        check("rst rdata", RDATA, 0);
        check("rst strobes", {READ_STROBE, WRITE_STROBE}, 0);
        check("rst acks", {ACK0, ACK1}, 0);
        check("rst d3 busy", d3_busy, 0);

        // Test 1: master 0 write from reset
        do_reset();
        REQ0 = 1; WE0 = 1; ADDR0 = 16'h4003; WDATA0 = 16'h00A5;
        cyc();  // cycle 1
        check("w0 c1 port_id", PORT_ID, 16'h4003);
        check("w0 c1 busy", BUSY, 1);
        check("w0 c1 ws", WRITE_STROBE, 0);
        check("w0 c1 rs", READ_STROBE, 0);
        cyc();  // cycle 2
        check("w0 c2 ws", WRITE_STROBE, 1);
        check("w0 c2 out_port", OUT_PORT, 16'h00A5);
        check("w0 c2 port_id", PORT_ID, 16'h4003);
        check("w0 c2 rs", READ_STROBE, 0);
        check("w0 c2 ack0", ACK0, 0);
        cyc();  // cycle 3
        check("w0 c3 ack0", ACK0, 1);
        check("w0 c3 ack1", ACK1, 0);
        check("w0 c3 ws", WRITE_STROBE, 0);
        check("w0 c3 rs", READ_STROBE, 0);
        check("w0 c3 busy", BUSY, 1);
        REQ0 = 0;
        cyc();  // cycle 4
        check("w0 c4 ack0", ACK0, 0);
        check("w0 c4 busy", BUSY, 0);
        check("w0 c4 port_id hold", PORT_ID, 16'h4003);
        check("w0 c4 out_port hold", OUT_PORT, 16'h00A5);

        // Test 2: master 1 read, RD_LAT=1
        do_reset();
        REQ1 = 1; WE1 = 0; ADDR1 = 16'h0002; IN_PORT = 16'h1234;
        cyc();  // cycle 1
        check("r1 c1 port_id", PORT_ID, 16'h0002);
        check("r1 c1 grant", GRANT, 1);
        check("r1 c1 rs", READ_STROBE, 0);
        cyc();  // cycle 2
        check("r1 c2 rs", READ_STROBE, 1);
        check("r1 c2 ws", WRITE_STROBE, 0);
        cyc();  // cycle 3
        check("r1 c3 rs", READ_STROBE, 0);
        check("r1 c3 ack1", ACK1, 0);
        check("r1 c3 busy", BUSY, 1);
        cyc();  // cycle 4
        check("r1 c4 ack1", ACK1, 1);
        check("r1 c4 ack0", ACK0, 0);
        check("r1 c4 rdata", RDATA, 16'h1234);
        check("r1 c4 grant", GRANT, 1);
        REQ1 = 0; IN_PORT = 16'h5555;
        cyc();  // cycle 5
        check("r1 c5 ack1", ACK1, 0);
        check("r1 c5 rdata hold", RDATA, 16'h1234);
        check("r1 c5 busy", BUSY, 0);

        // Test 3: both masters hold write requests continuously
        do_reset();
        REQ0 = 1; WE0 = 1; ADDR0 = 16'h4001; WDATA0 = 16'h0011;
        REQ1 = 1; WE1 = 1; ADDR1 = 16'h8002; WDATA1 = 16'h0022;
        for (int c = 1; c <= 16; c++) begin
            cyc();
            check($sformatf("rr c%0d ack0", c), ACK0, (c == 3 || c == 11));
            check($sformatf("rr c%0d ack1", c), ACK1, (c == 7 || c == 15));
            check($sformatf("rr c%0d ws", c), WRITE_STROBE, (c % 4 == 2));
            check($sformatf("rr c%0d rs", c), READ_STROBE, 0);
            check($sformatf("rr c%0d grant", c), GRANT, (((c - 1) / 4) % 2));
            check($sformatf("rr c%0d busy", c), BUSY, (c % 4 != 0));
        end

        // Test 4: reset during the STROBE cycle of a master 1 write
        do_reset();
        REQ1 = 1; WE1 = 1; ADDR1 = 16'h8005; WDATA1 = 16'h0055;
        cyc();  // cycle 1
        check("ab c1 grant", GRANT, 1);
        cyc();  // cycle 2
        check("ab c2 ws", WRITE_STROBE, 1);
        #2 RESET = 1'b0;
        #1;
        check("ab async ws", WRITE_STROBE, 0);
        check("ab async busy", BUSY, 0);
        check("ab async ack1", ACK1, 0);
        check("ab async port_id", PORT_ID, 0);
        REQ0 = 1; WE0 = 1; ADDR0 = 16'h4009; WDATA0 = 16'h0009;
        @(posedge CLK);
        @(negedge CLK);
        check("ab in reset ack1", ACK1, 0);
        RESET = 1'b1;
        cyc();  // cycle 1 after release
        check("ab rel c1 grant", GRANT, 0);
        check("ab rel c1 port_id", PORT_ID, 16'h4009);
        check("ab rel c1 ack1", ACK1, 0);
        cyc();  // cycle 2
        check("ab rel c2 ws", WRITE_STROBE, 1);
        check("ab rel c2 out_port", OUT_PORT, 16'h0009);
        cyc();  // cycle 3
        check("ab rel c3 ack0", ACK0, 1);
        check("ab rel c3 ack1", ACK1, 0);

        // Test 5: master 0 read, REQ0 and request fields change after grant
        do_reset();
        REQ0 = 1; WE0 = 0; ADDR0 = 16'h0007; IN_PORT = 16'hBEEF;
        cyc();  // cycle 1
        REQ0 = 0; WE0 = 1; ADDR0 = 16'h7777; WDATA0 = 16'hFFFF;
        check("dr c1 port_id", PORT_ID, 16'h0007);
        cyc();  // cycle 2
        check("dr c2 rs", READ_STROBE, 1);
        check("dr c2 ws", WRITE_STROBE, 0);
        check("dr c2 port_id", PORT_ID, 16'h0007);
        cyc();  // cycle 3
        check("dr c3 rs", READ_STROBE, 0);
        check("dr c3 ack0", ACK0, 0);
        cyc();  // cycle 4
        check("dr c4 ack0", ACK0, 1);
        check("dr c4 rdata", RDATA, 16'hBEEF);
        for (int c = 5; c <= 8; c++) begin
            cyc();
            check($sformatf("dr c%0d busy", c), BUSY, 0);
            check($sformatf("dr c%0d strobes", c), {READ_STROBE, WRITE_STROBE}, 0);
            check($sformatf("dr c%0d ack0", c), ACK0, 0);
        end

        // Test 6: RD_LAT=3 instance, master 0 read with IN_PORT changing
        do_reset();
        REQ0 = 1; WE0 = 0; ADDR0 = 16'h000A; IN_PORT = 16'h0000;
        cyc();  // cycle 1
        check("l3 c1 port_id", d3_port_id, 16'h000A);
        cyc();  // cycle 2
        check("l3 c2 rs", d3_rs, 1);
        cyc();  // cycle 3: WAIT 1
        IN_PORT = 16'h0001;
        check("l3 c3 rs", d3_rs, 0);
        check("l3 c3 ack0", d3_ack0, 0);
        cyc();  // cycle 4: WAIT 2
        IN_PORT = 16'h0002;
        check("l3 c4 ack0", d3_ack0, 0);
        check("l1 c4 ack0", ACK0, 1);
        check("l1 c4 rdata", RDATA, 16'h0001);
        cyc();  // cycle 5: WAIT 3
        IN_PORT = 16'h0003;
        check("l3 c5 ack0", d3_ack0, 0);
        check("l3 c5 busy", d3_busy, 1);
        cyc();  // cycle 6: DONE
        REQ0 = 0;
        check("l3 c6 ack0", d3_ack0, 1);
        check("l3 c6 ack1", d3_ack1, 0);
        check("l3 c6 rdata", d3_rdata, 16'h0003);
        cyc();  // cycle 7
        check("l3 c7 ack0", d3_ack0, 0);
        check("l3 c7 busy", d3_busy, 0);

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
